hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 19 +
 rtl/hazard_forward_unit_fwd_mux.sv | 52 +++++
 rtl/hazard_forward_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: forwarding source codes,
// stall FSM states and the stall statistics counter width.
package hazard_pkg;

   localparam int STALL_CNT_W = 16;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_mux.sv
// One read port's forwarding select: compares the source index against the
// EX, MEM and WB destinations and picks the youngest valid producer.
// The WB inputs are tied off by the top when HAZARD_WB_FWD_EN is undefined,
// so the WB branch can never win and FWD_WB is never produced.
module fwd_mux
   import hazard_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic [AW-1:0]   i_rs_idx,
   input  logic [XLEN-1:0] i_rf_val,
   input  logic            i_ex_valid,
   input  logic            i_ex_is_load,
   input  logic [AW-1:0]   i_ex_rd_idx,
   input  logic [XLEN-1:0] i_ex_result,
   input  logic            i_mem_valid,
   input  logic            i_mem_is_load,
   input  logic [AW-1:0]   i_mem_rd_idx,
   input  logic [XLEN-1:0] i_mem_alu_res,
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic            i_wb_valid,
   input  logic [AW-1:0]   i_wb_rd_idx,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [XLEN-1:0] o_val,
   output logic [1:0]      o_sel
);

   fwd_sel_e w_sel;

   // Priority select: x0 is never forwarded; a load in EX has no data yet.
   always_comb begin
      w_sel = FWD_RF;
      o_val = i_rf_val;
      if (i_rs_idx == '0) begin
         w_sel = FWD_RF;
         o_val = i_rf_val;
      end else if (i_ex_valid && !i_ex_is_load && (i_ex_rd_idx == i_rs_idx)) begin
         w_sel = FWD_EX;
         o_val = i_ex_result;
      end else if (i_mem_valid && (i_mem_rd_idx == i_rs_idx)) begin
         w_sel = FWD_MEM;
         o_val = i_mem_is_load ? i_mem_rdata : i_mem_alu_res;
      end else if (i_wb_valid && (i_wb_rd_idx == i_rs_idx)) begin
         w_sel = FWD_WB;
         o_val = i_wb_data;
      end
   end

   assign o_sel = w_sel;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the ID->EX boundary.
// Detects load-use hazards and stalls PC/IF/ID for LOAD_LAT cycles,
// inserting bubbles; otherwise registers the forwarded operands.
// Optional WB forwarding: define HAZARD_WB_FWD_EN.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NRP      = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   flush_i,
   input  logic                   id_valid_i,
   input  logic [NRP*AW-1:0]      id_rs_idx_i,
   input  logic [NRP*XLEN-1:0]    id_rs_val_i,
   input  logic                   ex_valid_i,
   input  logic [AW-1:0]          ex_rd_idx_i,
   input  logic                   ex_is_load_i,
   input  logic [XLEN-1:0]        ex_result_i,
   input  logic                   mem_valid_i,
   input  logic [AW-1:0]          mem_rd_idx_i,
   input  logic                   mem_is_load_i,
   input  logic [XLEN-1:0]        mem_alu_res_i,
   input  logic [XLEN-1:0]        mem_rdata_i,
`ifdef HAZARD_WB_FWD_EN
   input  logic                   wb_valid_i,
   input  logic [AW-1:0]          wb_rd_idx_i,
   input  logic [XLEN-1:0]        wb_data_i,
`endif
   output logic                   stall_o,
   output logic                   exe_valid_o,
   output logic [NRP*XLEN-1:0]    exe_rs_val_o,
   output logic [NRP*2-1:0]       fwd_sel_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam int CNT_W = $clog2(LOAD_LAT + 1);

   hz_state_e               r_state;
   hz_state_e               w_next_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_next_cnt;
   logic                    w_idx_match;
   logic                    w_hazard;
   logic                    w_stall;
   logic                    r_exe_valid;
   logic [NRP*XLEN-1:0]     r_exe_rs_val;
   logic [NRP*2-1:0]        r_fwd_sel;
   logic [STALL_CNT_W-1:0]  r_stall_cnt;
   logic [NRP*XLEN-1:0]     w_fwd_val;
   logic [NRP*2-1:0]        w_fwd_sel;
   logic                    w_wb_valid;
   logic [AW-1:0]           w_wb_rd_idx;
   logic [XLEN-1:0]         w_wb_data;

`ifdef HAZARD_WB_FWD_EN
   assign w_wb_valid  = wb_valid_i;
   assign w_wb_rd_idx = wb_rd_idx_i;
   assign w_wb_data   = wb_data_i;
`else
   assign w_wb_valid  = 1'b0;
   assign w_wb_rd_idx = '0;
   assign w_wb_data   = '0;
`endif

   genvar g;
   generate
      for (g = 0; g < NRP; g++) begin : g_port
         fwd_mux #(
            .XLEN (XLEN),
            .AW   (AW)
         ) u_fwd_mux (
            .i_rs_idx      (id_rs_idx_i[g*AW +: AW]),
            .i_rf_val      (id_rs_val_i[g*XLEN +: XLEN]),
            .i_ex_valid    (ex_valid_i),
            .i_ex_is_load  (ex_is_load_i),
            .i_ex_rd_idx   (ex_rd_idx_i),
            .i_ex_result   (ex_result_i),
            .i_mem_valid   (mem_valid_i),
            .i_mem_is_load (mem_is_load_i),
            .i_mem_rd_idx  (mem_rd_idx_i),
            .i_mem_alu_res (mem_alu_res_i),
            .i_mem_rdata   (mem_rdata_i),
            .i_wb_valid    (w_wb_valid),
            .i_wb_rd_idx   (w_wb_rd_idx),
            .i_wb_data     (w_wb_data),
            .o_val         (w_fwd_val[g*XLEN +: XLEN]),
            .o_sel         (w_fwd_sel[g*2 +: 2])
         );
      end
   endgenerate

   // Does any read port consume the register the EX-stage load will write?
   always_comb begin
      w_idx_match = 1'b0;
      for (int p = 0; p < NRP; p++) begin
         if (id_rs_idx_i[p*AW +: AW] == ex_rd_idx_i) w_idx_match = 1'b1;
      end
   end

   assign w_hazard = id_valid_i & ex_valid_i & ex_is_load_i &
                     (ex_rd_idx_i != '0) & w_idx_match;

   // Stall FSM next-state: flush and reset override; stall is combinational.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_stall      = 1'b0;
      if (!reset_i || flush_i) begin
         w_next_state = RUN;
         w_next_cnt   = '0;
      end else if (r_state == RUN) begin
         if (w_hazard) begin
            w_stall      = 1'b1;
            w_next_cnt   = CNT_W'(LOAD_LAT - 1);
            w_next_state = (LOAD_LAT > 1) ? STALL : RUN;
         end
      end else begin
         w_stall    = 1'b1;
         w_next_cnt = r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) w_next_state = RUN;
      end
   end

   // Stall FSM state and remaining-cycle counter.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // EX-entry register: bubble and hold while stalled, else capture operands.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_exe_valid  <= 1'b0;
         r_exe_rs_val <= '0;
         r_fwd_sel    <= '0;
      end else if (w_stall) begin
         r_exe_valid  <= 1'b0;
      end else begin
         r_exe_valid  <= id_valid_i & ~flush_i;
         r_exe_rs_val <= w_fwd_val;
         r_fwd_sel    <= w_fwd_sel;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign stall_o      = w_stall;
   assign exe_valid_o  = r_exe_valid;
   assign exe_rs_val_o = r_exe_rs_val;
   assign fwd_sel_o    = r_fwd_sel;
   assign stall_cnt_o  = r_stall_cnt;

endmodule
